// File: rtl/csi2_pkt_parser_if.sv
// Word stream from the DPHY slave into the packet parser.
interface csi2_pkt_parser_if;
    logic [31:0] data_i;
    logic        valid_i;

    modport master (output data_i, valid_i);
    modport slave  (input  data_i, valid_i);
endinterface

// File: rtl/csi2_pkt_parser.sv
// CSI-2 packet parser: header decode/ECC check, short-packet events,
// long-packet payload beats, CRC capture and end-of-packet resync pulse.
module csi2_pkt_parser #(
    parameter int unsigned EOP_HOLDOFF = 4,
    parameter bit          ECC_CHECK   = 1'b1
) (
    input  logic                    byte_clk,
    input  logic                    clk_loss_rst_d2,
    csi2_pkt_parser_if.slave        dphy,
    output logic                    sp_valid_o,
    output logic [5:0]              sp_dt_o,
    output logic [1:0]              sp_vc_o,
    output logic [15:0]             sp_data_o,
    output logic [5:0]              lp_dt_o,
    output logic [1:0]              lp_vc_o,
    output logic [31:0]             pkt_data_o,
    output logic [3:0]              pkt_be_o,
    output logic                    pkt_valid_o,
    output logic                    pkt_sop_o,
    output logic                    pkt_eop_o,
    output logic [15:0]             crc_o,
    output logic                    crc_valid_o,
    output logic                    ecc_err_o,
    output logic                    eop_o
);

    localparam int unsigned WC_W   = 16;
    localparam int unsigned REM_W  = WC_W + 1;
    localparam int unsigned HOLD_W = (EOP_HOLDOFF > 1) ? $clog2(EOP_HOLDOFF) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(EOP_HOLDOFF - 1);

    typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CRC_TAIL, S_HOLDOFF} state_t;

    typedef struct packed {
        logic [7:0]  ecc;
        logic [15:0] wc;
        logic [1:0]  vc;
        logic [5:0]  dt;
    } hdr_t;

    // CSI-2 v1 Hamming parity, one row mask per ECC bit
    function automatic logic [5:0] calc_ecc(input logic [23:0] d);
        logic [5:0] e;
        e[0] = ^(d & 24'hF12CB7);
        e[1] = ^(d & 24'hF2555B);
        e[2] = ^(d & 24'h749A6D);
        e[3] = ^(d & 24'hB8E38E);
        e[4] = ^(d & 24'hDF03F0);
        e[5] = ^(d & 24'hEFFC00);
        return e;
    endfunction

    state_t             state, state_d;
    hdr_t               hdr;
    logic               ecc_bad;
    logic               hdr_short;
    logic [REM_W-1:0]   rem_q, rem_d, bytes_left;
    logic               sop_pend_q, sop_pend_d;
    logic [7:0]         crc_lo_q, crc_lo_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;

    logic               sp_valid_d, pkt_valid_d, pkt_sop_d, pkt_eop_d;
    logic               crc_valid_d, ecc_err_d, eop_d;
    logic [5:0]         sp_dt_d, lp_dt_d;
    logic [1:0]         sp_vc_d, lp_vc_d;
    logic [15:0]        sp_data_d, crc_d;
    logic [31:0]        pkt_data_d;
    logic [3:0]         pkt_be_d;

    assign hdr        = hdr_t'(dphy.data_i);
    assign ecc_bad    = (hdr.ecc[5:0] != calc_ecc(dphy.data_i[23:0])) || (hdr.ecc[7:6] != 2'b00);
    assign hdr_short  = (hdr.dt <= 6'h0F);
    assign bytes_left = rem_q - REM_W'(2);

    // State register
    always_ff @(posedge byte_clk or posedge clk_loss_rst_d2) begin
        if (clk_loss_rst_d2) state <= S_IDLE;
        else                 state <= state_d;
    end

    // Next-state decode
    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE: begin
                if (dphy.valid_i) begin
                    if ((ecc_bad && ECC_CHECK) || hdr_short) state_d = S_HOLDOFF;
                    else                                     state_d = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (dphy.valid_i) begin
                    if (bytes_left == REM_W'(3))     state_d = S_CRC_TAIL;
                    else if (bytes_left < REM_W'(4)) state_d = S_HOLDOFF;
                end
            end
            S_CRC_TAIL: if (dphy.valid_i) state_d = S_HOLDOFF;
            S_HOLDOFF:  if (hold_q == '0) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Next values of outputs and datapath registers
    always_comb begin
        sp_valid_d  = 1'b0;
        pkt_valid_d = 1'b0;
        pkt_sop_d   = 1'b0;
        pkt_eop_d   = 1'b0;
        pkt_be_d    = 4'b0000;
        crc_valid_d = 1'b0;
        ecc_err_d   = 1'b0;
        eop_d       = 1'b0;
        sp_dt_d     = sp_dt_o;
        sp_vc_d     = sp_vc_o;
        sp_data_d   = sp_data_o;
        lp_dt_d     = lp_dt_o;
        lp_vc_d     = lp_vc_o;
        pkt_data_d  = pkt_data_o;
        crc_d       = crc_o;
        rem_d       = rem_q;
        sop_pend_d  = sop_pend_q;
        crc_lo_d    = crc_lo_q;
        hold_d      = hold_q;
        unique case (state)
            S_IDLE: begin
                if (dphy.valid_i) begin
                    ecc_err_d = ecc_bad;
                    if ((ecc_bad && ECC_CHECK) || hdr_short) begin
                        eop_d  = 1'b1;
                        hold_d = HOLD_LOAD;
                        if (!(ecc_bad && ECC_CHECK)) begin
                            sp_valid_d = 1'b1;
                            sp_dt_d    = hdr.dt;
                            sp_vc_d    = hdr.vc;
                            sp_data_d  = hdr.wc;
                        end
                    end else begin
                        lp_dt_d    = hdr.dt;
                        lp_vc_d    = hdr.vc;
                        rem_d      = REM_W'(hdr.wc) + REM_W'(2);
                        sop_pend_d = 1'b1;
                    end
                end
            end
            S_PAYLOAD: begin
                if (dphy.valid_i) begin
                    if (bytes_left >= REM_W'(4)) begin
                        pkt_valid_d = 1'b1;
                        pkt_data_d  = dphy.data_i;
                        pkt_be_d    = 4'b1111;
                        pkt_sop_d   = sop_pend_q;
                        pkt_eop_d   = (bytes_left == REM_W'(4));
                        sop_pend_d  = 1'b0;
                        rem_d       = rem_q - REM_W'(4);
                    end else begin
                        // Tail word: remaining payload bytes, then the CRC in the upper lanes
                        if (bytes_left != '0) begin
                            pkt_valid_d = 1'b1;
                            pkt_data_d  = dphy.data_i;
                            pkt_sop_d   = sop_pend_q;
                            pkt_eop_d   = 1'b1;
                            sop_pend_d  = 1'b0;
                        end
                        unique case (bytes_left[1:0])
                            2'd1:    begin pkt_be_d = 4'b0001; crc_d = dphy.data_i[23:8];  end
                            2'd2:    begin pkt_be_d = 4'b0011; crc_d = dphy.data_i[31:16]; end
                            2'd3:    begin pkt_be_d = 4'b0111; crc_lo_d = dphy.data_i[31:24]; end
                            default: begin crc_d = dphy.data_i[15:0]; end
                        endcase
                        if (bytes_left[1:0] != 2'd3) begin
                            crc_valid_d = 1'b1;
                            eop_d       = 1'b1;
                            hold_d      = HOLD_LOAD;
                        end
                    end
                end
            end
            S_CRC_TAIL: begin
                if (dphy.valid_i) begin
                    crc_d       = {dphy.data_i[7:0], crc_lo_q};
                    crc_valid_d = 1'b1;
                    eop_d       = 1'b1;
                    hold_d      = HOLD_LOAD;
                end
            end
            S_HOLDOFF: begin
                if (hold_q != '0) hold_d = hold_q - HOLD_W'(1);
            end
            default: ;
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge byte_clk or posedge clk_loss_rst_d2) begin
        if (clk_loss_rst_d2) begin
            sp_valid_o  <= 1'b0;
            sp_dt_o     <= '0;
            sp_vc_o     <= '0;
            sp_data_o   <= '0;
            lp_dt_o     <= '0;
            lp_vc_o     <= '0;
            pkt_data_o  <= '0;
            pkt_be_o    <= '0;
            pkt_valid_o <= 1'b0;
            pkt_sop_o   <= 1'b0;
            pkt_eop_o   <= 1'b0;
            crc_o       <= '0;
            crc_valid_o <= 1'b0;
            ecc_err_o   <= 1'b0;
            eop_o       <= 1'b0;
            rem_q       <= '0;
            sop_pend_q  <= 1'b0;
            crc_lo_q    <= '0;
            hold_q      <= '0;
        end else begin
            sp_valid_o  <= sp_valid_d;
            sp_dt_o     <= sp_dt_d;
            sp_vc_o     <= sp_vc_d;
            sp_data_o   <= sp_data_d;
            lp_dt_o     <= lp_dt_d;
            lp_vc_o     <= lp_vc_d;
            pkt_data_o  <= pkt_data_d;
            pkt_be_o    <= pkt_be_d;
            pkt_valid_o <= pkt_valid_d;
            pkt_sop_o   <= pkt_sop_d;
            pkt_eop_o   <= pkt_eop_d;
            crc_o       <= crc_d;
            crc_valid_o <= crc_valid_d;
            ecc_err_o   <= ecc_err_d;
            eop_o       <= eop_d;
            rem_q       <= rem_d;
            sop_pend_q  <= sop_pend_d;
            crc_lo_q    <= crc_lo_d;
            hold_q      <= hold_d;
        end
    end

endmodule
